spi_slave_interface: RTL and testbench

SPI mode-3 peripheral (responder) that sits at the far end of the team's SPI master link. It recovers frames of `DATASIZE` bits from externally driven `sclk`/`mosi`/`slave_select` by oversampling them on the 100 MHz system clock. It presents each received word with a one-cycle valid strobe and shifts a preloaded response word out on `miso`, MSB first. Its frame length and bit order match the master, so the two blocks interoperate directly, including back-to-back frames without chip-select release.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_interface.sv | 143 ++++++++++++++
 tb/tb_spi_slave_interface.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: state encoding, synchronizer depth
// and the default frame length, which has to match the SPI master.
package spi_pkg;

  localparam int DATASIZE    = 152;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous pin into the clk domain through a two-flop
// synchronizer, then one delay flop that provides rise/fall detection.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   delayed;

  // The reset value matches the pin's idle level, so no edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages  <= {SYNC_STAGES{INIT}};
      delayed <= INIT;
    end else begin
      stages  <= {stages[SYNC_STAGES-2:0], raw};
      delayed <= stages[SYNC_STAGES-1];
    end
  end

  assign synced = stages[SYNC_STAGES-1];
  assign rise   = synced & ~delayed;
  assign fall   = ~synced & delayed;

endmodule

// File: rtl/spi_slave_interface.sv
// SPI mode-3 responder: oversamples sclk/mosi/slave_select on clk, receives
// DATASIZE-bit frames and shifts a preloaded response word out on miso, MSB first.
module spi_slave_interface #(
  parameter int DATASIZE = spi_pkg::DATASIZE,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                slave_select,
  output logic                miso,
  input  logic [DATASIZE-1:0] tx_data,
  output logic [DATASIZE-1:0] rx_data,
  output logic                rx_valid,
  output logic                frame_error,
  output logic                busy
);

  import spi_pkg::*;

  state_t              state, state_next;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_next;
  logic [DATASIZE-1:0] tx_shift, tx_shift_next;
  logic [DATASIZE-1:0] rx_shift, rx_shift_next;
  logic [DATASIZE-1:0] rx_data_next, rx_word;
  logic                miso_next, rx_valid_next, frame_error_next;

  logic                   sclk_synced, sclk_rise, sclk_fall;
  logic                   ss_synced, ss_rise_unused, ss_fall_unused;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_act, mosi_synced;

  spi_sync_edge #(.INIT(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (sclk),
    .synced (sclk_synced),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  spi_sync_edge #(.INIT(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (slave_select),
    .synced (ss_synced),
    .rise   (ss_rise_unused),
    .fall   (ss_fall_unused)
  );

  // mosi sees the same two stages as sclk, so synced data lines up with the detected rise.
  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_synced = mosi_sync[SYNC_STAGES-1];
  assign ss_act      = ~ss_synced;
  assign rx_word     = {rx_shift[DATASIZE-2:0], mosi_synced};
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      miso        <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      tx_shift    <= tx_shift_next;
      rx_shift    <= rx_shift_next;
      miso        <= miso_next;
      rx_data     <= rx_data_next;
      rx_valid    <= rx_valid_next;
      frame_error <= frame_error_next;
    end
  end

  // The last rise publishes rx_data and the strobe together, so both are seen in COMPLETE.
  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    tx_shift_next    = tx_shift;
    rx_shift_next    = rx_shift;
    miso_next        = miso;
    rx_data_next     = rx_data;
    rx_valid_next    = 1'b0;
    frame_error_next = 1'b0;

    unique case (state)
      IDLE: begin
        miso_next = 1'b1;
        if (ss_act) begin
          state_next    = SHIFT;
          tx_shift_next = tx_data;
          bit_cnt_next  = '0;
        end
      end

      SHIFT: begin
        if (!ss_act) begin
          frame_error_next = (bit_cnt != '0);
          state_next       = IDLE;
          miso_next        = 1'b1;
        end else begin
          if (sclk_fall) begin
            miso_next     = tx_shift[DATASIZE-1];
            tx_shift_next = {tx_shift[DATASIZE-2:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_shift_next = rx_word;
            bit_cnt_next  = bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATASIZE - 1)) begin
              state_next    = COMPLETE;
              rx_data_next  = rx_word;
              rx_valid_next = 1'b1;
            end
          end
        end
      end

      COMPLETE: begin
        tx_shift_next = tx_data;
        bit_cnt_next  = '0;
        if (ss_act) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
          miso_next  = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_interface.sv
// Self-checking bench for spi_slave_interface with DATASIZE=16: a mode-3 master BFM
// drives directed and random frames; a word-level model predicts every result.
module tb_spi_slave_interface;

  localparam int DW   = 16;
  localparam int HALF = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          mosi;
  logic          slave_select;
  logic          miso;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_error;
  logic          busy;

  int            checks = 0;
  int            failures = 0;
  int            valid_cnt = 0;
  int            err_cnt = 0;
  logic [DW-1:0] last_rx = '0;

  spi_slave_interface #(.DATASIZE(DW), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .mosi         (mosi),
    .slave_select (slave_select),
    .miso         (miso),
    .tx_data      (tx_data),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts every cycle each strobe is high and keeps the word seen with rx_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        valid_cnt++;
        last_rx = rx_data;
      end
      if (frame_error) err_cnt++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic select_slave();
    slave_select = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic deselect_slave();
    slave_select = 1'b1;
    wait_clks(HALF);
  endtask

  // Mode-3 master: data changes on the falling sclk, both sides sample on the rising sclk.
  task automatic applyStimulus(input logic [DW-1:0] word, input logic [DW-1:0] next_tx,
                               input int nbits, input bit drop_on_last,
                               output logic [DW-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = word[DW-1-i];
      if (i == 4) tx_data = next_tx;
      wait_clks(HALF);
      got  = {got[DW-2:0], miso};
      sclk = 1'b1;
      if (drop_on_last && i == nbits - 1) slave_select = 1'b1;
      wait_clks(HALF);
    end
  endtask

  initial begin : stimulus
    logic [DW-1:0] got, got2, word, txw, model_rx;
    int            v0, e0, nb;
    bit            abort;

    rst = 1'b1; sclk = 1'b1; mosi = 1'b0; slave_select = 1'b1; tx_data = '0;
    model_rx = '0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(2);
    checkOutput("reset_miso", 16'(miso), 16'd1);
    checkOutput("reset_rx_data", rx_data, 16'h0000);
    checkOutput("reset_rx_valid", 16'(rx_valid), 16'd0);
    checkOutput("reset_frame_error", 16'(frame_error), 16'd0);
    checkOutput("reset_busy", 16'(busy), 16'd0);

    // Single frame.
    v0 = valid_cnt; e0 = err_cnt;
    tx_data = 16'h1234;
    select_slave();
    checkOutput("single_busy", 16'(busy), 16'd1);
    applyStimulus(16'hA5C3, 16'h1234, DW, 1'b0, got);
    deselect_slave();
    model_rx = 16'hA5C3;
    checkOutput("single_miso_word", got, 16'h1234);
    checkOutput("single_valid_pulses", 16'(valid_cnt - v0), 16'd1);
    checkOutput("single_valid_word", last_rx, model_rx);
    checkOutput("single_rx_data", rx_data, model_rx);
    checkOutput("single_no_error", 16'(err_cnt - e0), 16'd0);
    checkOutput("single_miso_idle", 16'(miso), 16'd1);
    checkOutput("single_busy_after", 16'(busy), 16'd0);

    // Back-to-back frames; the second response is loaded at the first frame's end.
    v0 = valid_cnt; e0 = err_cnt;
    tx_data = 16'h0F0F;
    select_slave();
    applyStimulus(16'hFFFF, 16'hBEEF, DW, 1'b0, got);
    checkOutput("b2b_first_word", last_rx, 16'hFFFF);
    checkOutput("b2b_still_busy", 16'(busy), 16'd1);
    applyStimulus(16'h0001, 16'hBEEF, DW, 1'b0, got2);
    deselect_slave();
    model_rx = 16'h0001;
    checkOutput("b2b_first_resp", got, 16'h0F0F);
    checkOutput("b2b_second_resp", got2, 16'hBEEF);
    checkOutput("b2b_valid_pulses", 16'(valid_cnt - v0), 16'd2);
    checkOutput("b2b_second_word", last_rx, model_rx);
    checkOutput("b2b_no_error", 16'(err_cnt - e0), 16'd0);

    // Aborted frame after 7 bits.
    v0 = valid_cnt; e0 = err_cnt;
    select_slave();
    applyStimulus(16'h3C3C, 16'hBEEF, 7, 1'b0, got);
    deselect_slave();
    checkOutput("abort_error_pulses", 16'(err_cnt - e0), 16'd1);
    checkOutput("abort_no_valid", 16'(valid_cnt - v0), 16'd0);
    checkOutput("abort_rx_kept", rx_data, model_rx);
    checkOutput("abort_idle", 16'(busy), 16'd0);
    checkOutput("abort_miso", 16'(miso), 16'd1);

    // Reset in the middle of a frame.
    select_slave();
    applyStimulus(16'hFFFF, 16'hBEEF, 9, 1'b0, got);
    rst = 1'b1;
    wait_clks(1);
    checkOutput("midrst_miso", 16'(miso), 16'd1);
    checkOutput("midrst_rx_data", rx_data, 16'h0000);
    checkOutput("midrst_rx_valid", 16'(rx_valid), 16'd0);
    checkOutput("midrst_frame_error", 16'(frame_error), 16'd0);
    checkOutput("midrst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    model_rx = '0;
    e0 = err_cnt;
    deselect_slave();
    checkOutput("midrst_no_error", 16'(err_cnt - e0), 16'd0);
    v0 = valid_cnt;
    tx_data = 16'hC001;
    select_slave();
    applyStimulus(16'h5A5A, 16'hC001, DW, 1'b0, got);
    deselect_slave();
    model_rx = 16'h5A5A;
    checkOutput("postrst_word", rx_data, model_rx);
    checkOutput("postrst_valid", 16'(valid_cnt - v0), 16'd1);
    checkOutput("postrst_resp", got, 16'hC001);

    // sclk noise while deselected.
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      wait_clks(5);
    end
    sclk = 1'b1;
    wait_clks(HALF);
    checkOutput("noise_no_valid", 16'(valid_cnt - v0), 16'd0);
    checkOutput("noise_no_error", 16'(err_cnt - e0), 16'd0);
    checkOutput("noise_miso", 16'(miso), 16'd1);
    checkOutput("noise_busy", 16'(busy), 16'd0);

    // Deselect coincident with the last rising sclk: the edge is discarded.
    v0 = valid_cnt; e0 = err_cnt;
    select_slave();
    applyStimulus(16'h9999, 16'hC001, DW, 1'b1, got);
    wait_clks(HALF);
    checkOutput("edge_drop_error", 16'(err_cnt - e0), 16'd1);
    checkOutput("edge_drop_no_valid", 16'(valid_cnt - v0), 16'd0);
    checkOutput("edge_drop_rx_kept", rx_data, model_rx);

    // Random frames, some aborted, against the word-level model.
    for (int f = 0; f < 10; f++) begin
      word  = 16'($urandom);
      txw   = 16'($urandom);
      abort = ($urandom_range(0, 3) == 0);
      nb    = abort ? int'($urandom_range(1, DW - 1)) : DW;
      v0 = valid_cnt; e0 = err_cnt;
      tx_data = txw;
      select_slave();
      applyStimulus(word, txw, nb, 1'b0, got);
      deselect_slave();
      if (!abort) model_rx = word;
      checkOutput($sformatf("rand%0d_valid", f), 16'(valid_cnt - v0), abort ? 16'd0 : 16'd1);
      checkOutput($sformatf("rand%0d_error", f), 16'(err_cnt - e0), abort ? 16'd1 : 16'd0);
      checkOutput($sformatf("rand%0d_rx_data", f), rx_data, model_rx);
      if (!abort) checkOutput($sformatf("rand%0d_resp", f), got, txw);
      checkOutput($sformatf("rand%0d_miso", f), 16'(miso), 16'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
